// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit holding the HI/LO pair.
// Runs MULT, MULTU, DIV and DIVU in 33 cycles, and MTHI/MTLO in a single cycle.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   start, op       request (sampled only while idle) and operation select
//   Rdata1, Rdata2  rs operand (multiplicand/dividend/MTxx source), rt operand
//   busy, done      iterating flag, one-cycle result-commit pulse
//   HI, LO          architectural HI/LO registers
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO write here
// S_RUN  | one shift-add / restoring-divide iteration per cycle
// S_FIN  | apply signs, commit HI/LO, pulse done
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;       // mul: {acc, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d; // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [2*WIDTH-1:0] prod_fin;

  always_comb begin
    // op[0]=0 selects the signed variants of both multiply and divide.
    // Negating 0x80000000 yields 0x80000000, which is its correct unsigned magnitude.
    sgn   = ~op[0];
    a_mag = (sgn && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
    b_mag = (sgn && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;

    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, p_q[WIDTH-1:1]};

    // Bit WIDTH of the trial difference set means the subtraction borrowed.
    div_trial = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {1'b0, opnd_q};
    div_step  = div_trial[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    prod_fin = neg_res_q ? -p_q : p_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d   = S_RUN;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_res_d = sgn & (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
              neg_rem_d = sgn & Rdata1[WIDTH-1];
              div0_d    = op[1] & (Rdata2 == '0);
              if (op[1]) begin
                opnd_d = b_mag;
                p_d    = {{WIDTH{1'b0}}, a_mag};
              end else begin
                opnd_d = a_mag;
                p_d    = {{WIDTH{1'b0}}, b_mag};
              end
            end
            3'b100:  hi_d = Rdata1;
            3'b101:  lo_d = Rdata1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        p_d   = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        if (is_div_q) begin
          // Divide by zero leaves the dividend magnitude as remainder, so after
          // re-applying the dividend sign HI equals Rdata1; only LO needs forcing.
          lo_d = div0_q ? '1 : prod_fin[WIDTH-1:0];
          hi_d = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        end else begin
          lo_d = prod_fin[WIDTH-1:0];
          hi_d = prod_fin[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: checks md_unit against a transaction-level model (a countdown of
// remaining latency plus a pending {HI,LO} computed with 64-bit arithmetic),
// compared every cycle, plus hand-computed directed results.
module tb_md_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] HI, LO;

  int nchecks = 0;
  int nerr    = 0;

  md_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op),
    .Rdata1(rs), .Rdata2(rt),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result {HI,LO} of an arithmetic op.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      3'd0: begin q = sa * sb; r = q; end
      3'd1: r = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Behavioural model: busy while latency remains; result lands when it runs out.
  logic        mvalid = 1'b0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge CLK) begin
    if (RST === 1'b1) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (op < 3'd4) begin
          m_pend = ref_result(op, rs, rt);
          m_left = 33;
        end else if (op == 3'd4) m_hi = rs;
        else if (op == 3'd5) m_lo = rs;
      end
    end
  end

  always @(negedge CLK) begin
    if (mvalid) begin
      chk("cyc busy", {63'b0, busy}, {63'b0, m_left > 0});
      chk("cyc done", {63'b0, done}, {63'b0, m_done});
      chk("cyc HI", {32'b0, HI}, {32'b0, m_hi});
      chk("cyc LO", {32'b0, LO}, {32'b0, m_lo});
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_idle", {63'b0, busy}, 64'd0);
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat, bc;
    wait_idle();
    @(negedge CLK);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge CLK);
    start = 1'b0;
    lat = 0; bc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      @(negedge CLK);
      lat++;
    end
    chk({nm, " latency"}, lat, 33);
    chk({nm, " busy cycles"}, bc, 33);
    chk({nm, " HI"}, {32'b0, HI}, {32'b0, eh});
    chk({nm, " LO"}, {32'b0, LO}, {32'b0, el});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    RST = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    chk("reset HI", {32'b0, HI}, 64'd0);
    chk("reset LO", {32'b0, LO}, 64'd0);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);

    // Reset at iteration 10 of a DIV: nothing reaches HI/LO.
    @(negedge CLK);
    start = 1'b1; op = 3'd2; rs = 32'h0000_7FFF; rt = 32'd3;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort busy", {63'b0, busy}, 64'd0);
    chk("abort HI", {32'b0, HI}, 64'd0);
    chk("abort LO", {32'b0, LO}, 64'd0);
    repeat (40) @(negedge CLK);
    chk("abort no done HI", {32'b0, HI}, 64'd0);
    chk("abort no done LO", {32'b0, LO}, 64'd0);

    do_op("MULTU max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("MULT -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("MULT min*min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    do_op("DIV -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("DIV min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    do_op("DIVU by 0", 3'd3, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    do_op("DIV -5 by 0", 3'd2, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    do_op("DIVU 100/7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    // MTHI while idle.
    @(negedge CLK);
    start = 1'b1; op = 3'd4; rs = 32'hDEAD_BEEF;
    @(negedge CLK);
    start = 1'b0;
    chk("MTHI HI", {32'b0, HI}, {32'b0, 32'hDEAD_BEEF});
    chk("MTHI busy", {63'b0, busy}, 64'd0);
    chk("MTHI LO kept", {32'b0, LO}, 64'd14);

    // Reserved op is a no-op.
    start = 1'b1; op = 3'd7; rs = 32'h1111_1111; rt = 32'h2;
    @(negedge CLK);
    start = 1'b0;
    chk("reserved busy", {63'b0, busy}, 64'd0);
    chk("reserved HI", {32'b0, HI}, {32'b0, 32'hDEAD_BEEF});

    // MTLO issued while busy is ignored.
    start = 1'b1; op = 3'd2; rs = 32'hFFFF_FFF9; rt = 32'd2;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    start = 1'b1; op = 3'd5; rs = 32'h5555_5555;
    @(negedge CLK);
    start = 1'b0;
    chk("MTLO busy LO", {32'b0, LO}, 64'd14);
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    chk("MTLO busy done", {63'b0, done}, 64'd1);
    chk("MTLO busy final LO", {32'b0, LO}, {32'b0, 32'hFFFF_FFFD});

    // start held high: re-accepted in the done cycle, fresh 33-cycle latency.
    wait_idle();
    @(negedge CLK);
    start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd5;
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    chk("held first done", {63'b0, done}, 64'd1);
    @(negedge CLK);
    chk("held reaccept busy", {63'b0, busy}, 64'd1);
    n = 1;
    while (done !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    chk("held done spacing", n, 34);
    start = 1'b0;
    chk("held LO", {32'b0, LO}, 64'd15);
    @(negedge CLK);
    chk("held released busy", {63'b0, busy}, 64'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      RST   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      rs    = pick();
      rt    = pick();
    end
    RST = 1'b0; start = 1'b0;

    // Hold reset two cycles after random activity.
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    chk("final reset HI", {32'b0, HI}, 64'd0);
    chk("final reset LO", {32'b0, LO}, 64'd0);
    chk("final reset busy", {63'b0, busy}, 64'd0);
    chk("final reset done", {63'b0, done}, 64'd0);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
